// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: state encoding,
// halt encoding and the jump-target table.
package fetch_pkg;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 9;
   localparam int LUT_W   = 5;
   localparam int LUT_N   = 1 << LUT_W;

   localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } state_t;

   typedef logic [PC_W-1:0] lut_t [LUT_N];

   // Default jump-target table; per-program tables override the jump_lut parameter.
   localparam lut_t JUMP_LUT = '{
      10'd0,
      10'd16,
      10'd32,
      10'd48,
      10'd64,
      10'd200,
      10'd300,
      10'd1023,
      10'd128,
      10'd10,
      10'd160,
      10'd176,
      10'd192,
      10'd208,
      10'd224,
      10'd240,
      10'd256,
      10'd272,
      10'd288,
      10'd304,
      10'd320,
      10'd336,
      10'd352,
      10'd368,
      10'd384,
      10'd400,
      10'd416,
      10'd432,
      10'd448,
      10'd464,
      10'd480,
      10'd496
   };

   // Jump always redirects; a branch redirects only when the ALU reports equality.
   function automatic logic take_target(input logic branch,
                                        input logic jump,
                                        input logic zero);
      return jump | (branch & zero);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data toward the instruction memory, and the
// instruction/decoder feedback loop toward the control decoder.
interface instr_fetch_if;
   import fetch_pkg::*;

   logic [PC_W-1:0]    rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic [INSTR_W-1:0] instr;
   logic               Branch;
   logic               Jump;
   logic               Zero;

   modport master (
      output rom_addr,
      output instr,
      input  rom_data,
      input  Branch,
      input  Jump,
      input  Zero
   );

   modport slave (
      input  rom_addr,
      input  instr,
      output rom_data,
      output Branch,
      output Jump,
      output Zero
   );

endinterface

// File: rtl/jump_lut.sv
// Combinational jump-target lookup; the table is a parameter so each program
// can bring its own targets.
module jump_lut
   import fetch_pkg::*;
#(
   parameter lut_t TABLE = JUMP_LUT
) (
   input  logic [LUT_W-1:0] idx,
   output logic [PC_W-1:0]  target
);

   assign target = TABLE[idx];

endmodule

// File: rtl/instr_fetch.sv
// PC sequencer and instruction-fetch stage: Start/Done program handshake,
// next-PC selection from decoder feedback, and a saturating RUN-cycle counter.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   instr_fetch_if.master    bus,
   output logic             Done,
   output logic [CNT_W-1:0] cycles,
   output state_t           state_dbg
);

   // Program handshake: Start held high parks the stage in LOAD (PC=0, counter
   // and Done cleared); the cycle after LOAD sees Start low is the first fetch
   // at PC 0. Done rises the cycle after HALT_INSTR is fetched and stays high
   // until the next Start. Start is ignored while running.

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    next_pc;
   logic [PC_W-1:0]    lut_target;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic               done_q, done_d;
   logic               halt_fetch;

   jump_lut u_jump_lut (
      .idx    (bus.rom_data[LUT_W-1:0]),
      .target (lut_target)
   );

   assign halt_fetch = (bus.rom_data == HALT_INSTR);
   assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // PC+1 wraps naturally at the PC width.
   always_comb begin
      next_pc = pc_q + PC_W'(1);
      if (take_target(bus.Branch, bus.Jump, bus.Zero)) begin
         next_pc = lut_target;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            pc_d = '0;
            if (Start) begin
               state_d = LOAD;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         LOAD: begin
            pc_d   = '0;
            cnt_d  = '0;
            done_d = 1'b0;
            if (!Start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_inc;
            // A halt fetch freezes the PC on the halt address.
            if (halt_fetch) begin
               state_d = HALT;
               done_d  = 1'b1;
            end else begin
               pc_d = next_pc;
            end
         end
         HALT: begin
            if (Start) begin
               state_d = LOAD;
               pc_d    = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.rom_addr = pc_q;
   assign bus.instr    = bus.rom_data;
   assign Done         = done_q;
   assign cycles       = cnt_q;
   assign state_dbg    = state_q;

endmodule
